id_ex_stage: RTL

//  ID/EX pipeline register sitting between decode (register-file read) and execute.

---
 rtl/id_ex_stage_if.sv | 75 +++++++
 rtl/id_ex_stage.sv | 128 ++++++++++++
 2 files changed

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: decode-side operands/control in, execute-side copies out,
// plus load-use stall, branch flush and write-back bypass signals.
interface id_ex_stage_if #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc;
    logic [XLEN-1:0]   id_pc4;
    logic [RA_W-1:0]   id_rs1_addr;
    logic [RA_W-1:0]   id_rs2_addr;
    logic [RA_W-1:0]   id_rd_addr;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [XLEN-1:0]   id_rs1_data;
    logic [XLEN-1:0]   id_rs2_data;
    logic [XLEN-1:0]   id_ext;
    logic              id_rf_we;
    logic [2:0]        id_rf_wsel;
    logic [CTRL_W-1:0] id_ctrl;

    logic              flush;
    logic              wb_we;
    logic [RA_W-1:0]   wb_rd;
    logic [XLEN-1:0]   wb_data;

    logic              stall_id;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc;
    logic [XLEN-1:0]   ex_pc4;
    logic [RA_W-1:0]   ex_rs1_addr;
    logic [RA_W-1:0]   ex_rs2_addr;
    logic [RA_W-1:0]   ex_rd_addr;
    logic [XLEN-1:0]   ex_rs1_data;
    logic [XLEN-1:0]   ex_rs2_data;
    logic [XLEN-1:0]   ex_ext;
    logic              ex_rf_we;
    logic [2:0]        ex_rf_wsel;
    logic [CTRL_W-1:0] ex_ctrl;

    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_pc, id_pc4,
        output id_rs1_addr, id_rs2_addr, id_rd_addr,
        output id_rs1_used, id_rs2_used,
        output id_rs1_data, id_rs2_data, id_ext,
        output id_rf_we, id_rf_wsel, id_ctrl,
        output flush, wb_we, wb_rd, wb_data,
        input  stall_id,
        input  ex_valid, ex_pc, ex_pc4,
        input  ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
        input  ex_rs1_data, ex_rs2_data, ex_ext,
        input  ex_rf_we, ex_rf_wsel, ex_ctrl,
        input  stall_cnt
    );

    modport slave (
        input  id_valid, id_pc, id_pc4,
        input  id_rs1_addr, id_rs2_addr, id_rd_addr,
        input  id_rs1_used, id_rs2_used,
        input  id_rs1_data, id_rs2_data, id_ext,
        input  id_rf_we, id_rf_wsel, id_ctrl,
        input  flush, wb_we, wb_rd, wb_data,
        output stall_id,
        output ex_valid, ex_pc, ex_pc4,
        output ex_rs1_addr, ex_rs2_addr, ex_rd_addr,
        output ex_rs1_data, ex_rs2_data, ex_ext,
        output ex_rf_we, ex_rf_wsel, ex_ctrl,
        output stall_cnt
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and stall counter.
// Define ID_WB_BYPASS_EN to forward the same-cycle write-back value into rs1/rs2.
`ifndef WB_ALU
`define WB_ALU  3'd0
`define WB_DM   3'd1
`define WB_PC_4 3'd2
`define WB_SEXT 3'd3
`endif

module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int RA_W   = 5,
    parameter int CTRL_W = 16,
    parameter int CNT_W  = 32
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [RA_W-1:0]   rs1_addr;
        logic [RA_W-1:0]   rs2_addr;
        logic [RA_W-1:0]   rd_addr;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   ext;
        logic              rf_we;
        logic [2:0]        rf_wsel;
        logic [CTRL_W-1:0] ctrl;
    } id_ex_t;

    id_ex_t           ex_q;
    id_ex_t           ex_d;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0]  rs1_val;
    logic [XLEN-1:0]  rs2_val;
    logic             ex_is_load;
    logic             rs1_hit;
    logic             rs2_hit;
    logic             load_use;
    logic             stall;

    // Only a valid load with a real destination can stall decode
    assign ex_is_load = ex_q.valid & ex_q.rf_we
                      & (ex_q.rf_wsel == `WB_DM)
                      & (ex_q.rd_addr != '0);

    assign rs1_hit = bus.id_rs1_used
                   & (bus.id_rs1_addr == ex_q.rd_addr);
    assign rs2_hit = bus.id_rs2_used
                   & (bus.id_rs2_addr == ex_q.rd_addr);

    assign load_use = ex_is_load & bus.id_valid
                    & (rs1_hit | rs2_hit);

    assign stall = load_use & ~bus.flush & ~rst;

`ifdef ID_WB_BYPASS_EN
    // Register file writes at the edge but reads combinationally
    always_comb begin
        rs1_val = bus.id_rs1_data;
        rs2_val = bus.id_rs2_data;
        if (bus.wb_we && (bus.wb_rd != '0)
            && (bus.wb_rd == bus.id_rs1_addr))
            rs1_val = bus.wb_data;
        if (bus.wb_we && (bus.wb_rd != '0)
            && (bus.wb_rd == bus.id_rs2_addr))
            rs2_val = bus.wb_data;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{bus.wb_we, bus.wb_rd, bus.wb_data};
    assign rs1_val   = bus.id_rs1_data;
    assign rs2_val   = bus.id_rs2_data;
`endif

    always_comb begin
        ex_d          = '0;
        ex_d.valid    = bus.id_valid;
        ex_d.pc       = bus.id_pc;
        ex_d.pc4      = bus.id_pc4;
        ex_d.rs1_addr = bus.id_rs1_addr;
        ex_d.rs2_addr = bus.id_rs2_addr;
        ex_d.rd_addr  = bus.id_rd_addr;
        ex_d.rs1_data = rs1_val;
        ex_d.rs2_data = rs2_val;
        ex_d.ext      = bus.id_ext;
        ex_d.rf_we    = bus.id_rf_we & bus.id_valid;
        ex_d.rf_wsel  = bus.id_rf_wsel;
        ex_d.ctrl     = bus.id_ctrl;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ex_q <= '0;
        else if (bus.flush || load_use)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (stall && (cnt_q != '1))
            cnt_q <= cnt_q + CNT_W'(1);
    end

    assign bus.stall_id    = stall;
    assign bus.stall_cnt   = cnt_q;
    assign bus.ex_valid    = ex_q.valid;
    assign bus.ex_pc       = ex_q.pc;
    assign bus.ex_pc4      = ex_q.pc4;
    assign bus.ex_rs1_addr = ex_q.rs1_addr;
    assign bus.ex_rs2_addr = ex_q.rs2_addr;
    assign bus.ex_rd_addr  = ex_q.rd_addr;
    assign bus.ex_rs1_data = ex_q.rs1_data;
    assign bus.ex_rs2_data = ex_q.rs2_data;
    assign bus.ex_ext      = ex_q.ext;
    assign bus.ex_rf_we    = ex_q.rf_we;
    assign bus.ex_rf_wsel  = ex_q.rf_wsel;
    assign bus.ex_ctrl     = ex_q.ctrl;

endmodule
